// File: rtl/mult4_acc.sv
// mult4_acc: accumulates LEN consecutive 8-bit products from the 4x4
// multiplier into an ACC_W-bit sum.
// Products arrive on a valid/ready input handshake.
// The finished sum is offered on a valid/ready output handshake.
// Optional build macro: MULT4_ACC_SAT_EN.
//   Defined:   on a carry the sum clamps to all-ones.
//   Undefined: the sum wraps modulo 2^ACC_W.
// In both builds ovf records that a carry occurred during the batch.
module mult4_acc #(
    parameter int ACC_W = 12,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic [7:0]       cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Count value at which the next accept completes the batch.
    localparam logic [7:0] LAST = 8'(LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_add;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             accept;
    logic             rel;

    // One bit wider than the accumulator so that the top bit is the carry.
    assign sum   = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod};
    assign carry = sum[ACC_W];

    // Value loaded into the accumulator on an accept.
    always_comb begin
`ifdef MULT4_ACC_SAT_EN
        acc_add = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_add = sum[ACC_W-1:0];
`endif
    end

    // Next state and handshake decode.
    // in_ready and out_valid depend only on the registered state.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and infers a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        rel       = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid && !clear;
                if (accept && cnt == LAST) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                rel       = out_ready;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
        // clear aborts the batch from either state and discards a held result.
        if (clear) begin
            state_nxt = ACCUM;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers update with <= so every flop samples pre-edge values, whatever order the statements are in.
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator, count and sticky overflow.
    // clear and release take priority over accept.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: reset drops the batch immediately and asynchronously, so no result is ever produced for it.
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clear || rel) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            acc <= acc_add;
            cnt <= cnt + 8'd1;
            ovf <= ovf | carry;
        end
    end

    assign acc_out = acc;

endmodule
